// File: rtl/lsu_mem_access.sv
// lsu_mem_access
//   Load/store access unit sitting between execute and the load-extension
//   decoder. One request is accepted at a time, the byte-lane data-memory
//   port is driven until mem_ack (or a timeout), and a single-cycle response
//   carries the read word shifted down to bits [7:0] plus the extension
//   select code.
//
// Ports
//   clk, rst_n                  clock (rising edge), async active-low reset
//   req_valid/req_ready         request handshake (ready only in IDLE)
//   req_we, req_funct3          store flag and RV32 size/sign code
//   req_addr, req_wdata         byte address and store data
//   mem_req/mem_we/mem_addr     memory strobe, write enable, word address
//   mem_be, mem_wdata           byte lane enables, lane-replicated data
//   mem_ack, mem_rdata          memory completion pulse and read word
//   rsp_valid                   one-cycle response pulse
//   rsp_data, rsp_sel, rsp_err  shifted read word, extension select, status

module lsu_mem_access #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_data,
  output logic [2:0]        rsp_sel,
  output logic [1:0]        rsp_err
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        off_q, off_d;
  logic [2:0]        sel_q, sel_d;
  logic              req_ready_q, req_ready_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic [2:0]        rsp_sel_q, rsp_sel_d;
  logic [1:0]        rsp_err_q, rsp_err_d;

  logic              dec_illegal;
  logic              dec_misalign;
  logic [3:0]        dec_be;
  logic [31:0]       dec_wdata;
  logic [2:0]        dec_sel;

  // Request decode: lane enables, replicated store data, extension select
  // and the two early-error conditions. Unsigned loads have no store form,
  // so bu/hu with we=1 is treated as an illegal encoding.
  always_comb begin
    dec_illegal  = 1'b0;
    dec_misalign = 1'b0;
    dec_be       = 4'b0000;
    dec_wdata    = 32'd0;
    dec_sel      = 3'b000;
    case (req_funct3)
      3'b000, 3'b100: begin
        dec_be      = 4'b0001 << req_addr[1:0];
        dec_wdata   = {4{req_wdata[7:0]}};
        dec_sel     = req_funct3[2] ? 3'b100 : 3'b001;
        dec_illegal = req_we & req_funct3[2];
      end
      3'b001, 3'b101: begin
        dec_misalign = req_addr[0];
        dec_be       = 4'b0011 << req_addr[1:0];
        dec_wdata    = {2{req_wdata[15:0]}};
        dec_sel      = req_funct3[2] ? 3'b101 : 3'b010;
        dec_illegal  = req_we & req_funct3[2];
      end
      3'b010: begin
        dec_misalign = |req_addr[1:0];
        dec_be       = 4'b1111;
        dec_wdata    = req_wdata;
        dec_sel      = 3'b011;
      end
      default: dec_illegal = 1'b1;
    endcase
    if (req_we) begin
      dec_sel = 3'b000;
    end
  end

  // Next-state logic. Memory outputs are held while in ACCESS and cleared
  // on exit; the response fields are only non-zero for the single RESP
  // cycle, so every path defaults them to zero.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    off_d       = off_q;
    sel_d       = sel_q;
    req_ready_d = req_ready_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = 32'd0;
    rsp_sel_d   = 3'b000;
    rsp_err_d   = ERR_OK;

    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          if (dec_illegal || dec_misalign) begin
            // Illegal encoding takes priority over misalignment.
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = dec_illegal ? ERR_ILLEGAL : ERR_MISALIGN;
          end else begin
            state_d     = ACCESS;
            cnt_d       = '0;
            off_d       = req_addr[1:0];
            sel_d       = dec_sel;
            mem_req_d   = 1'b1;
            mem_we_d    = req_we;
            mem_addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
            mem_be_d    = dec_be;
            mem_wdata_d = dec_wdata;
          end
        end
      end

      ACCESS: begin
        if (mem_ack || (cnt_q == CNT_LAST)) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = '0;
          mem_be_d    = 4'b0000;
          mem_wdata_d = 32'd0;
          // An ack arriving on the last allowed cycle still completes.
          if (mem_ack) begin
            rsp_sel_d = sel_q;
            if (!mem_we_q) begin
              rsp_data_d = mem_rdata >> {off_q, 3'b000};
            end
          end else begin
            rsp_err_d = ERR_TIMEOUT;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      RESP: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end

      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
        mem_req_d   = 1'b0;
      end
    endcase
  end

  // Single state register for the FSM and all registered outputs; reset
  // drops mem_req immediately and discards any in-flight access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      off_q       <= 2'b00;
      sel_q       <= 3'b000;
      req_ready_q <= 1'b1;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= 4'b0000;
      mem_wdata_q <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'd0;
      rsp_sel_q   <= 3'b000;
      rsp_err_q   <= ERR_OK;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      off_q       <= off_d;
      sel_q       <= sel_d;
      req_ready_q <= req_ready_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_sel_q   <= rsp_sel_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = req_ready_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_sel   = rsp_sel_q;
  assign rsp_err   = rsp_err_q;

endmodule
